// File: rtl/selectmap_cfg_pkg.sv
// Shared types and helpers for the SelectMAP x8 configuration master.
// Holds the sequencer state encoding, the ERR_CODE values and small
// elaboration-time helpers used by the top level.
package selectmap_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PROG_LOW,
    WAIT_INIT,
    LOAD,
    CLK_LO,
    CLK_HI,
    WAIT_DONE,
    STARTUP,
    SUCCESS,
    ERROR
  } cfg_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_INIT_TO = 2'd1;
  localparam err_code_t ERR_CRC     = 2'd2;
  localparam err_code_t ERR_DONE_TO = 2'd3;

  // Larger of two integers, used to size shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reverse bit order of a byte (raw .bin streams are LSB-first on D0).
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/selectmap_cfg_if.sv
// Byte-stream source and SelectMAP pin bundle for the configuration master.
//
// Byte handshake: in the byte-fetch state the master takes DATA_IN and
// DATA_LAST on the rising CLK edge where DATA_VALID is high. DATA_READY is
// high for exactly one CLK cycle after that edge to say the byte was
// consumed; the source then presents the next byte (or drops DATA_VALID).
// DATA_VALID may stay low for any length of time without error.
interface selectmap_cfg_if;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       DATA_LAST;
  logic       DATA_READY;
  logic       PROG_B;
  logic       INIT_B;
  logic       FPGA_DONE;
  logic       FPGA_BUSY_B;
  logic       CCLK;
  logic       FPGA_CS_B;
  logic       FPGA_RDWR_B;
  logic [7:0] FPGA_D;

  modport master (
    input  DATA_IN, DATA_VALID, DATA_LAST, INIT_B, FPGA_DONE, FPGA_BUSY_B,
    output DATA_READY, PROG_B, CCLK, FPGA_CS_B, FPGA_RDWR_B, FPGA_D
  );

  modport slave (
    output DATA_IN, DATA_VALID, DATA_LAST, INIT_B, FPGA_DONE, FPGA_BUSY_B,
    input  DATA_READY, PROG_B, CCLK, FPGA_CS_B, FPGA_RDWR_B, FPGA_D
  );
endinterface

// File: rtl/cfg_sync2.sv
// Two-flop synchronizer for the asynchronous FPGA status pins.
// RST_VAL is the level the output shows while in reset.
module cfg_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/selectmap_cfg_master.sv
// Active SelectMAP x8 configuration master.
// Pulses PROG_B, waits for INIT_B, streams bytes onto FPGA_D with a
// generated CCLK (reissuing a byte when BUSY was low), watches DONE, runs
// the startup clocks and reports CFG_OK or CFG_ERR/ERR_CODE.
// Build option: define SELECTMAP_BITSWAP_EN to bit-reverse every byte at
// latch time so a raw .bin stream can be fed directly.
module selectmap_cfg_master
  import selectmap_cfg_pkg::*;
#(
  parameter int PROG_PULSE_CYCLES   = 64,
  parameter int INIT_TIMEOUT_CYCLES = 65535,
  parameter int CCLK_HALF           = 2,
  parameter int DONE_TIMEOUT_CCLKS  = 1024,
  parameter int STARTUP_CCLKS       = 8
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  START,
  selectmap_cfg_if.master       bus,
  output logic                  CFG_BUSY,
  output logic                  CFG_OK,
  output logic                  CFG_ERR,
  output logic [1:0]            ERR_CODE,
  output cfg_state_t            dbg_state
);

  // Phase counter covers PROG pulse, INIT wait and CCLK half periods;
  // edge counter covers DONE wait and startup rising edges.
  localparam int PH_MAX = max2(max2(PROG_PULSE_CYCLES, INIT_TIMEOUT_CYCLES), CCLK_HALF);
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int ED_MAX = max2(DONE_TIMEOUT_CCLKS, STARTUP_CCLKS);
  localparam int ED_W   = $clog2(ED_MAX) + 1;

  localparam logic [PH_W-1:0] PROG_LAST = PH_W'(PROG_PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] INIT_LAST = PH_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(CCLK_HALF - 1);
  localparam logic [ED_W-1:0] DONE_LIM  = ED_W'(DONE_TIMEOUT_CCLKS);
  localparam logic [ED_W-1:0] SU_LIM    = ED_W'(STARTUP_CCLKS);

  logic init_s, done_s, busy_b_s;

  cfg_sync2 #(.RST_VAL(1'b0)) u_sync_init (.clk(CLK), .rst_n(RST_B), .d(bus.INIT_B),      .q(init_s));
  cfg_sync2 #(.RST_VAL(1'b0)) u_sync_done (.clk(CLK), .rst_n(RST_B), .d(bus.FPGA_DONE),   .q(done_s));
  cfg_sync2 #(.RST_VAL(1'b1)) u_sync_busy (.clk(CLK), .rst_n(RST_B), .d(bus.FPGA_BUSY_B), .q(busy_b_s));

  logic [7:0] d_in;
`ifdef SELECTMAP_BITSWAP_EN
  assign d_in = bit_rev8(bus.DATA_IN);
`else
  assign d_in = bus.DATA_IN;
`endif

  cfg_state_t      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [ED_W-1:0] ed_q, ed_d;
  logic            prog_b_q, prog_b_d;
  logic            cclk_q, cclk_d;
  logic            cs_b_q, cs_b_d;
  logic [7:0]      fd_q, fd_d;
  logic            last_q, last_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  err_code_t       code_q, code_d;

  logic            err_go;
  err_code_t       err_sel;

  // Next-state and next-output logic for the configuration sequencer.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    ed_d     = ed_q;
    prog_b_d = prog_b_q;
    cclk_d   = cclk_q;
    cs_b_d   = cs_b_q;
    fd_d     = fd_q;
    last_d   = last_q;
    ready_d  = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    code_d   = code_q;
    err_go   = 1'b0;
    err_sel  = ERR_NONE;

    case (state_q)
      IDLE, SUCCESS, ERROR: begin
        if (START) begin
          state_d  = PROG_LOW;
          ph_d     = '0;
          prog_b_d = 1'b0;
          ok_d     = 1'b0;
          err_d    = 1'b0;
          code_d   = ERR_NONE;
        end
      end

      PROG_LOW: begin
        if (ph_q >= PROG_LAST) begin
          prog_b_d = 1'b1;
          state_d  = WAIT_INIT;
          ph_d     = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      WAIT_INIT: begin
        if (init_s) begin
          state_d = LOAD;
          cs_b_d  = 1'b0;
        end else if (ph_q >= INIT_LAST) begin
          err_go  = 1'b1;
          err_sel = ERR_INIT_TO;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      LOAD: begin
        if (!init_s) begin
          err_go  = 1'b1;
          err_sel = ERR_CRC;
        end else if (bus.DATA_VALID) begin
          fd_d    = d_in;
          last_d  = bus.DATA_LAST;
          ready_d = 1'b1;
          state_d = CLK_LO;
          ph_d    = '0;
        end
      end

      CLK_LO: begin
        if (!init_s) begin
          err_go  = 1'b1;
          err_sel = ERR_CRC;
        end else if (ph_q >= HALF_LAST) begin
          cclk_d  = 1'b1;
          state_d = CLK_HI;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      CLK_HI: begin
        if (!init_s) begin
          err_go  = 1'b1;
          err_sel = ERR_CRC;
        end else if (ph_q >= HALF_LAST) begin
          cclk_d = 1'b0;
          ph_d   = '0;
          if (!busy_b_s) begin
            state_d = CLK_LO;           // byte refused: same FPGA_D again
          end else if (last_q) begin
            state_d = WAIT_DONE;
            cs_b_d  = 1'b1;
            ed_d    = '0;
          end else begin
            state_d = LOAD;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!init_s) begin
          err_go  = 1'b1;
          err_sel = ERR_CRC;
        end else if (done_s) begin
          state_d = STARTUP;
          cclk_d  = 1'b0;
          ph_d    = '0;
          ed_d    = '0;
        end else if (ph_q >= HALF_LAST) begin
          ph_d = '0;
          if (cclk_q) begin
            cclk_d = 1'b0;
          end else if (ed_q >= DONE_LIM) begin
            err_go  = 1'b1;
            err_sel = ERR_DONE_TO;
          end else begin
            cclk_d = 1'b1;
            ed_d   = ed_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      STARTUP: begin
        if (ph_q >= HALF_LAST) begin
          ph_d = '0;
          if (cclk_q) begin
            cclk_d = 1'b0;
            if (ed_q >= SU_LIM) begin
              state_d = SUCCESS;
              ok_d    = 1'b1;
            end
          end else begin
            cclk_d = 1'b1;
            ed_d   = ed_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Any error parks the pins in a safe idle configuration.
    if (err_go) begin
      state_d  = ERROR;
      err_d    = 1'b1;
      code_d   = err_sel;
      cclk_d   = 1'b0;
      cs_b_d   = 1'b1;
      prog_b_d = 1'b1;
      ph_d     = '0;
    end

    busy_d = (state_d != IDLE) && (state_d != SUCCESS) && (state_d != ERROR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      ed_q     <= '0;
      prog_b_q <= 1'b1;
      cclk_q   <= 1'b0;
      cs_b_q   <= 1'b1;
      fd_q     <= 8'h00;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      ed_q     <= ed_d;
      prog_b_q <= prog_b_d;
      cclk_q   <= cclk_d;
      cs_b_q   <= cs_b_d;
      fd_q     <= fd_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign bus.PROG_B      = prog_b_q;
  assign bus.CCLK        = cclk_q;
  assign bus.FPGA_CS_B   = cs_b_q;
  assign bus.FPGA_RDWR_B = 1'b0;
  assign bus.FPGA_D      = fd_q;
  assign bus.DATA_READY  = ready_q;
  assign CFG_BUSY        = busy_q;
  assign CFG_OK          = ok_q;
  assign CFG_ERR         = err_q;
  assign ERR_CODE        = code_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/selectmap_cfg_master.md
Name: selectmap_cfg_master

Overview:
- Active SelectMAP x8 configuration master for the ML555 CPLD.
- Drives the FPGA from the writer side, replacing the Platform Flash that otherwise plays that role: it pulses PROG_B, waits for INIT_B, and clocks bytes from a local byte source onto the SelectMAP bus with a generated CCLK.
- Honours FPGA busy, watches DONE, then reports success or error.
- Sits in the CPLD between a byte-stream source (flash reader or host bridge) and the FPGA config pins.

Parameters:
- PROG_PULSE_CYCLES, 64: CLK cycles PROG_B is held low.
- INIT_TIMEOUT_CYCLES, 65535: max CLK cycles waiting for INIT_B high after PROG_B release.
- CCLK_HALF, 2: CLK cycles per CCLK half-period (>=1).
- DONE_TIMEOUT_CCLKS, 1024: CCLK rising edges allowed after the last byte for DONE to rise.
- STARTUP_CCLKS, 8: extra CCLK rising edges issued after DONE is seen.

Ports:
- CLK  in  1  system clock
- RST_B  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse, begin configuration
- DATA_IN  in  8  bitstream byte
- DATA_VALID  in  1  DATA_IN valid
- DATA_LAST  in  1  DATA_IN is the final byte (qualified by DATA_VALID)
- DATA_READY  out  1  one-cycle pulse, byte consumed
- PROG_B  out  1  FPGA PROG_B
- INIT_B  in  1  FPGA INIT_B (async)
- FPGA_DONE  in  1  FPGA DONE (async)
- FPGA_BUSY_B  in  1  FPGA BUSY, low = busy (async)
- CCLK  out  1  configuration clock
- FPGA_CS_B  out  1  SelectMAP chip select
- FPGA_RDWR_B  out  1  constant 0 (write only)
- FPGA_D  out  8  SelectMAP data
- CFG_BUSY  out  1  sequence in progress
- CFG_OK  out  1  sticky success
- CFG_ERR  out  1  sticky error
- ERR_CODE  out  2  1=INIT timeout, 2=CRC (INIT_B low during load), 3=DONE timeout

Behaviour:
- INIT_B, FPGA_DONE and FPGA_BUSY_B each pass through a 2-flop synchronizer. All decisions use the synced values.
- Reset values: PROG_B=1, CCLK=0, FPGA_CS_B=1, FPGA_RDWR_B=0, FPGA_D=0, DATA_READY=0, CFG_BUSY=0, CFG_OK=0, CFG_ERR=0, ERR_CODE=0, FSM=IDLE.
- Reset mid-operation returns every output to its reset value immediately. No partial byte completes.
- IDLE:
  - START moves to PROG_LOW and clears CFG_OK, CFG_ERR and ERR_CODE.
  - START is ignored in every state other than IDLE, SUCCESS and ERROR.
  - SUCCESS and ERROR behave like IDLE for START.
- PROG_LOW: PROG_B=0 for PROG_PULSE_CYCLES, then PROG_B=1 and move to WAIT_INIT.
- WAIT_INIT:
  - Synced INIT_B=1 moves to LOAD with FPGA_CS_B=0.
  - Counter reaching INIT_TIMEOUT_CYCLES moves to ERROR with code 1.
- LOAD: byte fetch.
  - If DATA_VALID=1: latch DATA_IN into FPGA_D and latch DATA_LAST. Pulse DATA_READY for exactly 1 CLK. Move to CLK_LO.
  - If DATA_VALID=0: hold with CCLK low. Stalling is legal, with no timeout.
- CLK_LO: CCLK=0 for CCLK_HALF cycles, then CLK_HI.
- CLK_HI: CCLK=1 for CCLK_HALF cycles. The FPGA samples on the rising edge. At the end of the high phase:
  - If synced FPGA_BUSY_B=0: the byte was not taken. Keep FPGA_D and return to CLK_LO to reissue.
  - Else if the latched last flag is set: move to WAIT_DONE with FPGA_CS_B=1.
  - Else: return to LOAD.
- During LOAD, CLK_LO and CLK_HI, synced INIT_B=0 moves to ERROR with code 2. This takes priority over all other transitions.
- WAIT_DONE:
  - Free-runs CCLK at CCLK_HALF.
  - Synced FPGA_DONE=1 moves to STARTUP.
  - Exceeding DONE_TIMEOUT_CCLKS rising edges moves to ERROR with code 3.
  - An INIT_B low error still applies here.
- STARTUP: issue STARTUP_CCLKS rising edges, then CCLK=0 and move to SUCCESS with CFG_OK=1.
- ERROR: CFG_ERR=1, ERR_CODE held, CCLK=0, FPGA_CS_B=1, PROG_B=1.
- CFG_BUSY=1 in every state except IDLE, SUCCESS and ERROR.
- Counters are sized with $clog2 of the parameter plus 1 and never wrap. Compare with >=.

Optional Feature:
- Macro SELECTMAP_BITSWAP_EN.
- Defined: FPGA_D[i] = DATA_IN[7-i] at latch time, so a raw .bin byte stream is accepted.
- Undefined: FPGA_D = DATA_IN unchanged.

Decomposition:
- Package selectmap_cfg_pkg holds:
  - FSM state enum: IDLE, PROG_LOW, WAIT_INIT, LOAD, CLK_LO, CLK_HI, WAIT_DONE, STARTUP, SUCCESS, ERROR.
  - ERR_CODE constants: ERR_NONE, ERR_INIT_TO, ERR_CRC, ERR_DONE_TO.
- One sub-module, cfg_sync2: a 2-flop synchronizer instantiated three times.

Test Plan:
- Nominal: START; INIT_B rises 10 cycles after PROG_B release; 16 bytes 0x00..0x0F with DATA_LAST on 0x0F; DONE rises after 4 CCLKs -> 16 DATA_READY pulses, each byte on FPGA_D at its CCLK rise, 8 startup CCLKs, CFG_OK=1, CFG_ERR=0.
- Busy: FPGA_BUSY_B=0 across the rising edge of byte 0x05 -> 0x05 is reissued on the next CCLK. The FPGA model receives exactly 16 bytes in order.
- INIT timeout: INIT_B held 0 with INIT_TIMEOUT_CYCLES=100 -> ERROR after 100 cycles, ERR_CODE=1, no CCLK edges.
- CRC: INIT_B driven 0 while byte 3 is loading -> ERROR, ERR_CODE=2, FPGA_CS_B=1 within 3 cycles of the INIT_B fall.
- DONE timeout with DONE_TIMEOUT_CCLKS=32: DONE never rises -> ERR_CODE=3 after 32 CCLK rises. A following START re-runs and clears the flags.
- Async reset asserted mid-CLK_HI, plus a DATA_VALID stall of 50 cycles -> outputs take reset values at once. The stall holds CCLK low with no error.
